// File: rtl/mpdmac_pkg.sv
// Shared definitions for the mirror-padding DMA configuration block:
// register offsets, sequencer states and default width limits.
package mpdmac_pkg;

    localparam logic [11:0] ADDR_VERSION  = 12'h000;
    localparam logic [11:0] ADDR_SRC      = 12'h100;
    localparam logic [11:0] ADDR_DST      = 12'h104;
    localparam logic [11:0] ADDR_WIDTH    = 12'h108;
    localparam logic [11:0] ADDR_CMD      = 12'h10C;
    localparam logic [11:0] ADDR_STATUS   = 12'h110;
    localparam logic [11:0] ADDR_INT_EN   = 12'h114;
    localparam logic [11:0] ADDR_INT_STAT = 12'h118;

    localparam logic [31:0] VERSION_DEF   = 32'h0001_0300;
    localparam int          MIN_WIDTH_DEF = 3;
    localparam int          MAX_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        RUN       = 2'd3
    } state_t;

endpackage

// File: rtl/mpdmac_apb_if.sv
// APB3 access-phase decode: register write strobes, read mux and slave error.
// An access is psel & penable; pready is always 1, so every access completes
// on the clock edge that ends its access phase and writes commit on that edge.
module mpdmac_apb_if
    import mpdmac_pkg::*;
(
    input  logic        psel,
    input  logic        penable,
    input  logic [11:0] paddr,
    input  logic        pwrite,
    input  logic        wdata_bit0,
    input  logic        busy,
    input  logic [31:0] version,
    input  logic [31:0] src,
    input  logic [31:0] dst,
    input  logic [5:0]  width,
    input  logic        width_err,
    input  logic        int_en,
    input  logic        int_stat,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic        we_src,
    output logic        we_dst,
    output logic        we_width,
    output logic        we_int_en,
    output logic        cmd_start,
    output logic        stat_clr
);

    logic        access;
    logic        wr;
    logic        mapped;
    logic        lock_err;
    logic [31:0] rd_val;

    assign access = psel & penable;
    assign wr     = access & pwrite;

    always_comb begin
        rd_val = '0;
        mapped = 1'b1;
        case (paddr)
            ADDR_VERSION:  rd_val = version;
            ADDR_SRC:      rd_val = src;
            ADDR_DST:      rd_val = dst;
            ADDR_WIDTH:    rd_val = {26'd0, width};
            ADDR_CMD:      rd_val = '0;
            ADDR_STATUS:   rd_val = {30'd0, width_err, ~busy};
            ADDR_INT_EN:   rd_val = {31'd0, int_en};
            ADDR_INT_STAT: rd_val = {31'd0, int_stat};
            default:       mapped = 1'b0;
        endcase
    end

    // Launch parameters are frozen while a transfer is in flight.
    assign lock_err = pwrite & busy &
                      ((paddr == ADDR_SRC) || (paddr == ADDR_DST) ||
                       (paddr == ADDR_WIDTH) ||
                       ((paddr == ADDR_CMD) && wdata_bit0));

    assign pslverr   = access & (~mapped | lock_err);
    assign prdata    = (psel & ~pwrite) ? rd_val : '0;

    assign we_src    = wr & ~busy & (paddr == ADDR_SRC);
    assign we_dst    = wr & ~busy & (paddr == ADDR_DST);
    assign we_width  = wr & ~busy & (paddr == ADDR_WIDTH);
    assign we_int_en = wr & (paddr == ADDR_INT_EN);
    assign cmd_start = wr & ~busy & (paddr == ADDR_CMD) & wdata_bit0;
    assign stat_clr  = wr & (paddr == ADDR_INT_STAT) & wdata_bit0;

endmodule

// File: rtl/mpdmac_cfg.sv
// Register file and launch sequencer for the mirror-padding DMA engine:
// validates the width, pulses start, tracks done and raises the interrupt.
module mpdmac_cfg
    import mpdmac_pkg::*;
#(
    parameter logic [31:0] VERSION   = VERSION_DEF,
    parameter int          MIN_WIDTH = MIN_WIDTH_DEF,
    parameter int          MAX_WIDTH = MAX_WIDTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [11:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o,
    output logic [31:0] src_addr_o,
    output logic [31:0] dst_addr_o,
    output logic [5:0]  mat_width_o,
    output logic        start_o,
    input  logic        done_i,
    output logic        irq_o,
    output logic [1:0]  dbg_state_o
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [5:0]  width_q;
    logic        width_err_q;
    logic        int_en_q;
    logic        int_stat_q;
    logic        busy;
    logic        width_ok;
    logic        we_src;
    logic        we_dst;
    logic        we_width;
    logic        we_int_en;
    logic        cmd_start;
    logic        stat_clr;

    mpdmac_apb_if u_apb_if (
        .psel       (psel_i),
        .penable    (penable_i),
        .paddr      (paddr_i),
        .pwrite     (pwrite_i),
        .wdata_bit0 (pwdata_i[0]),
        .busy       (busy),
        .version    (VERSION),
        .src        (src_q),
        .dst        (dst_q),
        .width      (width_q),
        .width_err  (width_err_q),
        .int_en     (int_en_q),
        .int_stat   (int_stat_q),
        .prdata     (prdata_o),
        .pslverr    (pslverr_o),
        .we_src     (we_src),
        .we_dst     (we_dst),
        .we_width   (we_width),
        .we_int_en  (we_int_en),
        .cmd_start  (cmd_start),
        .stat_clr   (stat_clr)
    );

    assign width_ok = ({26'd0, width_q} >= 32'(MIN_WIDTH)) &&
                      ({26'd0, width_q} <= 32'(MAX_WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (cmd_start && width_ok) state_d = LAUNCH;
            LAUNCH:    state_d = WAIT_BUSY;
            WAIT_BUSY: if (!done_i) state_d = RUN;
            RUN:       if (done_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        start_o = (state_q == LAUNCH);
        busy    = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q       <= '0;
            dst_q       <= '0;
            width_q     <= '0;
            width_err_q <= 1'b0;
            int_en_q    <= 1'b0;
            int_stat_q  <= 1'b0;
        end else begin
            if (we_src)    src_q    <= pwdata_i;
            if (we_dst)    dst_q    <= pwdata_i;
            if (we_width)  width_q  <= pwdata_i[5:0];
            if (we_int_en) int_en_q <= pwdata_i[0];
            if (cmd_start) width_err_q <= ~width_ok;
            // Completion takes priority over a same-cycle W1C.
            if ((state_q == RUN) && done_i) int_stat_q <= 1'b1;
            else if (stat_clr)              int_stat_q <= 1'b0;
        end
    end

    assign pready_o    = 1'b1;
    assign src_addr_o  = src_q;
    assign dst_addr_o  = dst_q;
    assign mat_width_o = width_q;
    assign irq_o       = int_stat_q & int_en_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mpdmac_cfg.sv
// Directed bench for mpdmac_cfg: register table plus launch, width-check,
// lock, collision and mid-run reset sequences.
module tb_mpdmac_cfg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [11:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [5:0]  mat_width;
    logic        start;
    logic        done = 1'b1;
    logic        irq;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int start_cnt = 0;

    logic [31:0] exp_q[$];

    mpdmac_cfg dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .psel_i      (psel),
        .penable_i   (penable),
        .paddr_i     (paddr),
        .pwrite_i    (pwrite),
        .pwdata_i    (pwdata),
        .pready_o    (pready),
        .prdata_o    (prdata),
        .pslverr_o   (pslverr),
        .src_addr_o  (src_addr),
        .dst_addr_o  (dst_addr),
        .mat_width_o (mat_width),
        .start_o     (start),
        .done_i      (done),
        .irq_o       (irq),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start) start_cnt <= start_cnt + 1;
    end

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that ends the access.
    task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        #2;
        rd  = prdata;
        err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        err;
        apb(1'b0, a, 32'h0, rd, err);
        check(name, rd, exp);
    endtask

    task automatic wr_chk(input string name, input logic [11:0] a, input logic [31:0] d,
                          input logic exp_err);
        logic [31:0] rd;
        logic        err;
        apb(1'b1, a, d, rd, err);
        check(name, {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic        err;
        apb(1'b1, a, d, rd, err);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;

        //            wr    addr     wdata          exp_rd         err
        vecs[0]  = '{1'b0, 12'h000, 32'h0,         32'h0001_0300, 1'b0};
        vecs[1]  = '{1'b0, 12'h200, 32'h0,         32'h0,         1'b1};
        vecs[2]  = '{1'b1, 12'h100, 32'h0000_1000, 32'h0,         1'b0};
        vecs[3]  = '{1'b1, 12'h104, 32'h0000_2000, 32'h0,         1'b0};
        vecs[4]  = '{1'b1, 12'h108, 32'hFFFF_FFC4, 32'h0,         1'b0};
        vecs[5]  = '{1'b1, 12'h114, 32'h0000_0001, 32'h0,         1'b0};
        vecs[6]  = '{1'b0, 12'h100, 32'h0,         32'h0000_1000, 1'b0};
        vecs[7]  = '{1'b0, 12'h104, 32'h0,         32'h0000_2000, 1'b0};
        vecs[8]  = '{1'b0, 12'h108, 32'h0,         32'h0000_0004, 1'b0};
        vecs[9]  = '{1'b0, 12'h114, 32'h0,         32'h0000_0001, 1'b0};
        vecs[10] = '{1'b0, 12'h10C, 32'h0,         32'h0,         1'b0};
        vecs[11] = '{1'b0, 12'h110, 32'h0,         32'h0000_0001, 1'b0};
        vecs[12] = '{1'b0, 12'h118, 32'h0,         32'h0,         1'b0};
        vecs[13] = '{1'b1, 12'h200, 32'hFFFF_FFFF, 32'h0,         1'b1};
        vecs[14] = '{1'b0, 12'h11C, 32'h0,         32'h0,         1'b1};
        vecs[15] = '{1'b0, 12'h100, 32'h0,         32'h0000_1000, 1'b0};

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("pready", {31'd0, pready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Register table
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(vecs[i].exp_rd);
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
            check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            if (!vecs[i].wr) check($sformatf("vec%0d_rd", i), rd, exp_q.pop_front());
            else void'(exp_q.pop_front());
        end
        check("src_out", src_addr, 32'h0000_1000);
        check("dst_out", dst_addr, 32'h0000_2000);
        check("width_out", {26'd0, mat_width}, 32'd4);

        // Normal launch with width 4
        wr(12'h10C, 32'h1);
        check("launch_start", {31'd0, start}, 32'd1);
        @(posedge clk); #1;
        check("launch_pulse_end", {31'd0, start}, 32'd0);
        check("wait_busy_state", {30'd0, dbg_state}, 32'd2);
        done = 1'b0;
        @(posedge clk); #1;
        check("run_state", {30'd0, dbg_state}, 32'd3);
        rd_chk("status_busy", 12'h110, 32'h0);
        repeat (46) @(posedge clk);
        #1;
        done = 1'b1;
        check("irq_before_done", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        check("irq_after_done", {31'd0, irq}, 32'd1);
        check("idle_after_done", {30'd0, dbg_state}, 32'd0);
        rd_chk("int_stat_set", 12'h118, 32'h1);
        rd_chk("status_idle", 12'h110, 32'h1);
        wr(12'h118, 32'h1);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        check("start_count1", start_cnt, 32'd1);

        // Width check: 2 rejected
        wr(12'h108, 32'd2);
        wr(12'h10C, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("w2_no_start", start_cnt, 32'd1);
        rd_chk("w2_status", 12'h110, 32'h3);

        // Width 32 accepted, then lock while busy
        wr(12'h108, 32'd32);
        wr(12'h10C, 32'h1);
        check("w32_start", {31'd0, start}, 32'd1);
        @(posedge clk); #1;
        done = 1'b0;
        @(posedge clk); #1;
        rd_chk("w32_status", 12'h110, 32'h0);
        wr_chk("lock_src_err", 12'h100, 32'hDEAD_0000, 1'b1);
        wr_chk("lock_cmd_err", 12'h10C, 32'h1, 1'b1);
        rd_chk("lock_src_kept", 12'h100, 32'h0000_1000);
        check("lock_no_start", start_cnt, 32'd2);

        // W1C colliding with done rising in RUN
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h118; pwdata = 32'h1;
        @(posedge clk); #1;
        penable = 1'b1;
        done = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        check("collide_irq", {31'd0, irq}, 32'd1);
        rd_chk("collide_stat", 12'h118, 32'h1);

        // Width 33 rejected
        wr(12'h108, 32'd33);
        wr(12'h10C, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("w33_no_start", start_cnt, 32'd2);
        rd_chk("w33_status", 12'h110, 32'h3);

        // Asynchronous reset mid-RUN
        wr(12'h108, 32'd5);
        wr(12'h10C, 32'h1);
        @(posedge clk); #1;
        done = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_run", {30'd0, dbg_state}, 32'd3);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
        check("mid_rst_start", {31'd0, start}, 32'd0);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        done = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd_chk("post_rst_status", 12'h110, 32'h1);
        rd_chk("post_rst_src", 12'h100, 32'h0);
        rd_chk("post_rst_dst", 12'h104, 32'h0);
        rd_chk("post_rst_width", 12'h108, 32'h0);
        rd_chk("post_rst_int_en", 12'h114, 32'h0);
        rd_chk("post_rst_int_stat", 12'h118, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
